if_fetch_queue: RTL and testbench

Instruction-fetch initiator on the memctrl IF port.
- Drives the fetch request and address to memctrl and holds them until memctrl signals completion.
- Pushes each returned word, tagged with its PC, into a small instruction queue that feeds the decoder.
- Handles jump redirects: flushes the queue and squashes any in-flight fetch.

---
 rtl/if_fetch_queue_pkg.sv | 32 +++
 rtl/if_fetch_queue_if.sv | 36 +++
 rtl/if_fetch_queue_inst_fifo.sv | 74 +++++++
 rtl/if_fetch_queue.sv | 142 ++++++++++++++
 tb/tb_if_fetch_queue.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_queue_pkg
// Shared types and constants for the instruction-fetch queue slice:
//   INST_W / ADDR_W     instruction and address widths
//   RESET_PC_DEFAULT    default fetch PC after reset
//   fetch_state_e       fetch FSM encoding (IDLE, REQ)
//   fetch_entry_t       one queue entry, {pc, inst}
//   align_pc()          word-aligns a redirect target
// ---------------------------------------------------------------------------
package if_fetch_queue_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Instructions are word aligned; the low two bits of a redirect are dropped.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// if_fetch_queue_if
// IF-port bundle between the fetch unit and memctrl.
//   if_read_or_not         fetch request (fetch unit -> memctrl)
//   intru_addr             fetch address (fetch unit -> memctrl)
//   if_load_done           one-cycle completion pulse (memctrl -> fetch unit)
//   mem_ctrl_instru_to_if  fetched word, valid with if_load_done
//   mem_ctrl_busy_state    [1] IF access in progress, [0] MEM access in progress
// Modports: master = fetch unit, slave = memctrl.
// ---------------------------------------------------------------------------
interface if_fetch_queue_if;
  import if_fetch_queue_pkg::*;

  logic              if_read_or_not;
  logic [ADDR_W-1:0] intru_addr;
  logic              if_load_done;
  logic [INST_W-1:0] mem_ctrl_instru_to_if;
  logic [1:0]        mem_ctrl_busy_state;

  modport master (
    output if_read_or_not,
    output intru_addr,
    input  if_load_done,
    input  mem_ctrl_instru_to_if,
    input  mem_ctrl_busy_state
  );

  modport slave (
    input  if_read_or_not,
    input  intru_addr,
    output if_load_done,
    output mem_ctrl_instru_to_if,
    output mem_ctrl_busy_state
  );

endinterface

// File: rtl/if_fetch_queue_inst_fifo.sv
// ---------------------------------------------------------------------------
// if_inst_fifo
// Synchronous FIFO of {pc, inst} entries feeding the decoder.
//   clk_in    clock, rising edge
//   rst_in    asynchronous active-low reset (pointers and count only)
//   push      write wr_entry at the tail
//   pop       retire the head entry (ignored when empty)
//   clear     synchronous flush; wins over push and pop
//   wr_entry  entry to write
//   rd_entry  head entry, all zero when empty
//   count     number of valid entries
//   empty     count == 0
//   full      count == QUEUE_DEPTH
// ---------------------------------------------------------------------------
module if_inst_fifo
  import if_fetch_queue_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int PTR_W       = 2
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t rd_entry,
  output logic [PTR_W:0] count,
  output logic         empty,
  output logic         full
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(QUEUE_DEPTH);

  fetch_entry_t     mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;
  logic             pop_ok;

  assign empty  = (count_q == '0);
  assign full   = (count_q == DEPTH_CNT);
  assign count  = count_q;
  assign pop_ok = pop && !empty;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (clear) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // Pointers wrap naturally because QUEUE_DEPTH is a power of two.
      if (push)   tail_q <= tail_q + 1'b1;
      if (pop_ok) head_q <= head_q + 1'b1;
      case ({push, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is data only; validity is carried entirely by count_q.
  always_ff @(posedge clk_in) begin
    if (push && !clear) mem[tail_q] <= wr_entry;
  end

  assign rd_entry = empty ? '0 : mem[head_q];

endmodule

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
// Instruction-fetch initiator on the memctrl IF port. Issues one fetch at a
// time, holds request/address until memctrl completes, queues {pc, inst}
// for the decoder and handles jump redirects (flush + squash).
//   clk_in       clock, rising edge
//   rst_in       asynchronous active-low reset
//   rdy_in       global ready; low freezes all state
//   mem_if       IF-port bundle to memctrl (master side)
//   jump_en      one-cycle redirect request (highest priority)
//   jump_target  redirect PC (low two bits ignored)
//   inst_valid   queue head valid
//   inst         queue head instruction (0 when empty)
//   inst_pc      queue head PC (0 when empty)
//   inst_ready   decoder accepts the head
// ---------------------------------------------------------------------------
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int                QUEUE_DEPTH = 4,
  parameter int                PTR_W       = 2,
  parameter logic [ADDR_W-1:0] RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  if_fetch_queue_if.master  mem_if,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(QUEUE_DEPTH);

  fetch_state_e      state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  logic              fifo_push, fifo_pop, fifo_clear;
  logic              fifo_empty, fifo_full;
  logic [PTR_W:0]    fifo_count;
  fetch_entry_t      fifo_wr, fifo_rd;

  logic              space_avail;

  assign space_avail = (fifo_count < DEPTH_CNT);

  assign fifo_wr.pc   = addr_q;
  assign fifo_wr.inst = mem_if.mem_ctrl_instru_to_if;

  if_inst_fifo #(
    .QUEUE_DEPTH (QUEUE_DEPTH),
    .PTR_W       (PTR_W)
  ) u_inst_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .clear    (fifo_clear),
    .wr_entry (fifo_wr),
    .rd_entry (fifo_rd),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    pc_d       = pc_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_clear = 1'b0;

    if (rdy_in) begin
      if (jump_en) begin
        // Redirect squashes the in-flight fetch and discards any done/pop
        // of this cycle; the request stays low for at least one cycle so
        // memctrl restarts its access cleanly.
        fifo_clear = 1'b1;
        pc_d       = align_pc(jump_target);
        state_d    = ST_IDLE;
        req_d      = 1'b0;
      end else begin
        fifo_pop = !fifo_empty && inst_ready;
        case (state_q)
          ST_IDLE: begin
            // A done seen here belongs to a squashed fetch and is dropped.
            // Space is judged on the current count, so a fetch is only
            // issued when its result is guaranteed a slot.
            if (space_avail && !mem_if.mem_ctrl_busy_state[0]) begin
              state_d = ST_REQ;
              req_d   = 1'b1;
              addr_d  = pc_q;
            end
          end
          ST_REQ: begin
            if (mem_if.if_load_done) begin
              // The slot was reserved at issue; the full guard only stops a
              // stray memctrl pulse from corrupting the head.
              fifo_push = !fifo_full || fifo_pop;
              pc_d      = pc_q + 32'd4;
              req_d     = 1'b0;
              state_d   = ST_IDLE;
            end
          end
          default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
    end
  end

  assign mem_if.if_read_or_not = req_q;
  assign mem_if.intru_addr     = addr_q;

  assign inst_valid = !fifo_empty;
  assign inst       = fifo_rd.inst;
  assign inst_pc    = fifo_rd.pc;

endmodule

// File: tb/tb_if_fetch_queue.sv
`timescale 1ns/1ps
module tb_if_fetch_queue;
  import if_fetch_queue_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] KEY    = 32'hA5A5_A5A5;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_target = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  if_fetch_queue_if bus ();

  if_fetch_queue #(
    .QUEUE_DEPTH (DEPTH),
    .PTR_W       (2),
    .RESET_PC    (RST_PC)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .mem_if      (bus.master),
    .jump_en     (jump_en),
    .jump_target (jump_target),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected {pc,inst} stream and the next fetch PC.
  logic [63:0] exp_q[$];
  logic [31:0] mpc = RST_PC;

  // Stimulus controls
  logic        ctl_rdy = 1'b1, ctl_ready = 1'b1, ctl_busy0 = 1'b0;
  logic        ctl_jump = 1'b0;
  logic [31:0] ctl_tgt = '0;
  logic        rand_mode = 1'b0, stale_mode = 1'b0;
  logic        jump_on_done = 1'b0, freeze_on_done = 1'b0, force_done = 1'b0;
  int          freeze_cnt = 0;

  // memctrl model
  logic        serving = 1'b0;
  int          cnt = 0;

  // Values driven during the cycle that the next edge will consume
  logic        d_rdy = 1'b0, d_jump = 1'b0, d_done = 1'b0, d_req = 1'b0;
  logic [31:0] d_tgt = '0;

  task automatic step();
    logic done;
    logic prev_jump;
    @(posedge clk_in);
    #1;
    // Commit what the edge that just passed did, by the behavioural rules.
    if (rst_in && d_rdy) begin
      if (d_jump) begin
        exp_q.delete();
        mpc = {d_tgt[31:2], 2'b00};
      end else if (d_done && d_req) begin
        exp_q.push_back({mpc, mpc ^ KEY});
        mpc = mpc + 32'd4;
      end
    end
    prev_jump = d_jump && d_rdy;
    done = 1'b0;
    if (!bus.if_read_or_not) begin
      if (serving && prev_jump && stale_mode) done = 1'b1;
      serving = 1'b0;
    end else begin
      if (!serving) begin
        serving = 1'b1;
        cnt = rand_mode ? int'($urandom_range(0, 6)) : 5;
      end
      if (cnt == 0) begin
        done = 1'b1;
        cnt = rand_mode ? int'($urandom_range(0, 6)) : 5;
      end else begin
        cnt--;
      end
    end
    if (force_done) begin
      done = 1'b1;
      force_done = 1'b0;
    end
    if (freeze_on_done && done) begin
      freeze_on_done = 1'b0;
      freeze_cnt = 3;
    end
    if (freeze_cnt > 0) begin
      rdy_in = 1'b0;
      freeze_cnt--;
    end else begin
      rdy_in = ctl_rdy;
    end
    inst_ready = ctl_ready;
    jump_en = 1'b0;
    if (ctl_jump) begin
      jump_en = 1'b1;
      jump_target = ctl_tgt;
      ctl_jump = 1'b0;
    end
    if (jump_on_done && done) begin
      jump_en = 1'b1;
      jump_target = ctl_tgt;
      inst_ready = 1'b1;
      jump_on_done = 1'b0;
    end
    bus.if_load_done = done;
    bus.mem_ctrl_instru_to_if = done ? (bus.intru_addr ^ KEY) : $urandom();
    bus.mem_ctrl_busy_state = {serving, ctl_busy0};
    d_rdy = rdy_in;
    d_jump = jump_en;
    d_tgt = jump_target;
    d_done = done;
    d_req = bus.if_read_or_not;
  endtask

  // Monitor / scoreboard
  logic        have_prev = 1'b0;
  logic        p_req, p_done, p_rdy, p_jump, p_busy0;
  logic [31:0] p_addr;
  int          p_cnt;
  int          mon_n;
  logic [31:0] req_log[$];
  logic [31:0] last_rise = 32'h1;
  logic        saw_wrap = 1'b0;

  always @(negedge clk_in) begin
    if (!rst_in) begin
      check("rst_req", bus.if_read_or_not, 1'b0);
      check("rst_addr", bus.intru_addr, RST_PC);
      check("rst_valid", inst_valid, 1'b0);
      check("rst_inst", inst, 32'h0);
      check("rst_inst_pc", inst_pc, 32'h0);
      have_prev = 1'b0;
    end else begin
      mon_n = exp_q.size();
      check("inst_valid", inst_valid, mon_n != 0);
      if (mon_n != 0) begin
        check("head_pc", inst_pc, exp_q[0][63:32]);
        check("head_inst", inst, exp_q[0][31:0]);
      end else begin
        check("empty_pc", inst_pc, 32'h0);
        check("empty_inst", inst, 32'h0);
      end
      if (have_prev) begin
        if (!p_rdy) begin
          check("freeze_req", bus.if_read_or_not, p_req);
          check("freeze_addr", bus.intru_addr, p_addr);
        end else if (p_jump) begin
          check("jump_req_low", bus.if_read_or_not, 1'b0);
        end else if (p_req) begin
          check("req_until_done", bus.if_read_or_not, !p_done);
          if (bus.if_read_or_not) check("addr_hold", bus.intru_addr, p_addr);
        end else begin
          check("issue_rule", bus.if_read_or_not, (p_cnt < DEPTH) && !p_busy0);
        end
        if (!p_req && bus.if_read_or_not) begin
          check("issue_addr", bus.intru_addr, mpc);
          req_log.push_back(bus.intru_addr);
          if (bus.intru_addr == 32'h0 && last_rise == 32'hFFFF_FFFC) saw_wrap = 1'b1;
          last_rise = bus.intru_addr;
        end
      end
      if (mon_n != 0 && inst_ready && !jump_en && rdy_in) void'(exp_q.pop_front());
      p_req   = bus.if_read_or_not;
      p_addr  = bus.intru_addr;
      p_done  = bus.if_load_done;
      p_rdy   = rdy_in;
      p_jump  = jump_en;
      p_busy0 = bus.mem_ctrl_busy_state[0];
      p_cnt   = mon_n;
      have_prev = 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  logic        save_req, save_valid;
  logic [31:0] save_addr;

  initial begin
    bus.if_load_done = 1'b0;
    bus.mem_ctrl_instru_to_if = '0;
    bus.mem_ctrl_busy_state = 2'b00;

    // Reset, then streaming with a ready decoder
    repeat (3) step();
    rst_in = 1'b1;
    for (int i = 0; i < 200 && req_log.size() < 3; i++) step();
    check("p1_three_requests", req_log.size() >= 3, 1'b1);
    if (req_log.size() >= 3) begin
      check("p1_req0", req_log[0], 32'h0);
      check("p1_req1", req_log[1], 32'h4);
      check("p1_req2", req_log[2], 32'h8);
    end

    // Stalled decoder fills the queue, then one pop frees a slot
    ctl_ready = 1'b0;
    for (int i = 0; i < 300 && exp_q.size() < DEPTH; i++) step();
    check("p2_filled", exp_q.size(), DEPTH);
    repeat (5) step();
    check("p2_full_no_req", bus.if_read_or_not, 1'b0);
    check("p2_full_valid", inst_valid, 1'b1);
    ctl_ready = 1'b1;
    step();
    ctl_ready = 1'b0;
    step();
    step();
    check("p2_reissue_req", bus.if_read_or_not, 1'b1);
    check("p2_reissue_addr", bus.intru_addr, mpc);

    // MEM access in progress blocks issue
    ctl_ready = 1'b1;
    ctl_busy0 = 1'b1;
    step();
    for (int i = 0; i < 100 && bus.if_read_or_not; i++) step();
    for (int i = 0; i < 10; i++) begin
      step();
      check("p3_busy_no_req", bus.if_read_or_not, 1'b0);
    end
    ctl_busy0 = 1'b0;
    step();
    step();
    check("p3_resume_req", bus.if_read_or_not, 1'b1);
    check("p3_resume_addr", bus.intru_addr, mpc);

    // Jump during REQ, stale done the following cycle
    stale_mode = 1'b1;
    for (int i = 0; i < 100 && !bus.if_read_or_not; i++) step();
    check("p4_in_req", bus.if_read_or_not, 1'b1);
    ctl_tgt = 32'h0000_1006;
    ctl_jump = 1'b1;
    step();
    step();
    check("p4_req_dropped", bus.if_read_or_not, 1'b0);
    check("p4_queue_flushed", inst_valid, 1'b0);
    step();
    check("p4_reissue_req", bus.if_read_or_not, 1'b1);
    check("p4_reissue_addr", bus.intru_addr, 32'h0000_1004);
    check("p4_stale_not_queued", inst_valid, 1'b0);

    // Jump coinciding with done and a pop
    ctl_ready = 1'b0;
    for (int i = 0; i < 300 && exp_q.size() < 2; i++) step();
    check("p5_prefill", exp_q.size() >= 2, 1'b1);
    ctl_tgt = 32'h0000_2000;
    jump_on_done = 1'b1;
    for (int i = 0; i < 100 && jump_on_done; i++) step();
    check("p5_jump_fired", jump_on_done, 1'b0);
    ctl_ready = 1'b1;
    step();
    check("p5_queue_empty", inst_valid, 1'b0);
    check("p5_req_low", bus.if_read_or_not, 1'b0);
    step();
    check("p5_resume_req", bus.if_read_or_not, 1'b1);
    check("p5_resume_addr", bus.intru_addr, 32'h0000_2000);

    // rdy_in low for three cycles while done is pulsed mid-REQ
    freeze_on_done = 1'b1;
    for (int i = 0; i < 100 && freeze_on_done; i++) step();
    check("p6_freeze_fired", freeze_on_done, 1'b0);
    save_req = bus.if_read_or_not;
    save_addr = bus.intru_addr;
    save_valid = inst_valid;
    repeat (3) step();
    check("p6_frozen_req", bus.if_read_or_not, save_req);
    check("p6_frozen_addr", bus.intru_addr, save_addr);
    check("p6_frozen_valid", inst_valid, save_valid);
    repeat (20) step();

    // PC wraps from 0xFFFFFFFC to 0
    ctl_tgt = 32'hFFFF_FFF9;
    ctl_jump = 1'b1;
    repeat (60) step();
    check("p7_pc_wrap", saw_wrap, 1'b1);

    // Randomized traffic
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      ctl_rdy   = ($urandom_range(0, 9) != 0);
      ctl_ready = 1'($urandom_range(0, 1));
      ctl_busy0 = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 39) == 0) begin
        ctl_jump = 1'b1;
        ctl_tgt = $urandom();
      end
      step();
    end

    // Reset asserted mid-REQ, followed by a stale done
    rand_mode = 1'b0;
    ctl_rdy = 1'b1;
    ctl_ready = 1'b1;
    ctl_busy0 = 1'b0;
    repeat (2) step();
    for (int i = 0; i < 100 && !bus.if_read_or_not; i++) step();
    check("p9_in_req", bus.if_read_or_not, 1'b1);
    rst_in = 1'b0;
    #1;
    check("p9_async_req_drop", bus.if_read_or_not, 1'b0);
    check("p9_async_addr", bus.intru_addr, RST_PC);
    exp_q.delete();
    mpc = RST_PC;
    serving = 1'b0;
    step();
    force_done = 1'b1;
    step();
    rst_in = 1'b1;
    step();
    step();
    check("p9_restart_req", bus.if_read_or_not, 1'b1);
    check("p9_restart_addr", bus.intru_addr, RST_PC);
    check("p9_stale_ignored", inst_valid, 1'b0);
    repeat (30) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
